// File: rtl/pci_initiator.sv
// PCI bus-master initiator: runs an address phase followed by 1-4 data phases
// against a single target. Handles target wait states, master abort when no
// target claims the cycle, and stall termination when a claiming target
// withholds trdy too long. Read data is captured in a 4-entry read buffer;
// write data comes from a 4-entry write buffer preloaded by the host.
module pci_initiator #(
  parameter int DEVSEL_TIMEOUT = 4,
  parameter int WAIT_LIMIT     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cmd_write,
  input  logic [31:0] start_addr,
  input  logic [2:0]  xfer_len,
  input  logic [3:0]  byte_en,
  input  logic        wbuf_load,
  input  logic [1:0]  wbuf_idx,
  input  logic [31:0] wbuf_data,
  input  logic [1:0]  rbuf_idx,
  output logic [31:0] rbuf_data,
  inout  wire  [31:0] ad,
  output logic [3:0]  cbe,
  output logic        frame,
  output logic        irdy,
  input  logic        trdy,
  input  logic        devsel,
  output logic        busy,
  output logic        done,
  output logic        err_abort,
  output logic        err_timeout,
  output logic [2:0]  words_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_TURN = 2'd3
  } state_t;

  localparam logic [7:0] DEV_LAST  = 8'(DEVSEL_TIMEOUT - 1);
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  state_t      state_q, state_d;
  logic        cmd_write_q, cmd_write_d;
  logic [2:0]  len_q, len_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  wd_q, wd_d;
  logic [7:0]  dev_cnt_q, dev_cnt_d;
  logic        dev_seen_q, dev_seen_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        frame_q, frame_d;
  logic        irdy_q, irdy_d;
  logic [3:0]  cbe_q, cbe_d;
  logic [31:0] ad_q, ad_d;
  logic        ad_oe_q, ad_oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_abort_q, err_abort_d;
  logic        err_timeout_q, err_timeout_d;
  logic [31:0] wbuf_q [4];
  logic [31:0] wbuf_d [4];
  logic [31:0] rbuf_q [4];
  logic [31:0] rbuf_d [4];
  logic        dev_seen_now_s;
  logic        finish_s;

  // The bus is only driven from the registered enable, so reset releases it at once.
  assign ad          = ad_oe_q ? ad_q : {32{1'bz}};
  assign cbe         = cbe_q;
  assign frame       = frame_q;
  assign irdy        = irdy_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_abort   = err_abort_q;
  assign err_timeout = err_timeout_q;
  assign words_done  = wd_q;
  assign rbuf_data   = rbuf_q[rbuf_idx];

  // Next-state and next-output computation for the transaction sequencer.
  always_comb begin
    state_d        = state_q;
    cmd_write_d    = cmd_write_q;
    len_d          = len_q;
    be_d           = be_q;
    wd_d           = wd_q;
    dev_cnt_d      = dev_cnt_q;
    dev_seen_d     = dev_seen_q;
    wait_cnt_d     = wait_cnt_q;
    frame_d        = frame_q;
    irdy_d         = irdy_q;
    cbe_d          = cbe_q;
    ad_d           = ad_q;
    ad_oe_d        = ad_oe_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    err_abort_d    = err_abort_q;
    err_timeout_d  = err_timeout_q;
    wbuf_d         = wbuf_q;
    rbuf_d         = rbuf_q;
    dev_seen_now_s = dev_seen_q | ~devsel;
    finish_s       = 1'b0;

    // Host loads are accepted only while no transaction is in flight.
    if (wbuf_load && !busy_q) begin
      wbuf_d[wbuf_idx] = wbuf_data;
    end else begin
      wbuf_d = wbuf_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((xfer_len != 3'd0) && (xfer_len <= 3'd4)) begin
            cmd_write_d   = cmd_write;
            len_d         = xfer_len;
            be_d          = byte_en;
            wd_d          = 3'd0;
            err_abort_d   = 1'b0;
            err_timeout_d = 1'b0;
            busy_d        = 1'b1;
            state_d       = S_ADDR;
            frame_d       = 1'b0;
            irdy_d        = 1'b1;
            ad_d          = start_addr;
            ad_oe_d       = 1'b1;
            cbe_d         = cmd_write ? 4'b0011 : 4'b0010;
          end else begin
            // Illegal length: report completion without touching the bus.
            done_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ADDR: begin
        state_d    = S_DATA;
        irdy_d     = 1'b0;
        cbe_d      = be_q;
        frame_d    = (len_q == 3'd1);
        ad_d       = wbuf_q[2'd0];
        // Reads float ad right away; the target owns it during read data.
        ad_oe_d    = cmd_write_q;
        dev_cnt_d  = 8'd0;
        dev_seen_d = 1'b0;
        wait_cnt_d = 8'd0;
      end

      S_DATA: begin
        dev_seen_d = dev_seen_now_s;
        if (!trdy) begin
          // Completion takes priority over any timeout in the same cycle.
          if (!cmd_write_q) begin
            rbuf_d[wd_q[1:0]] = ad;
          end else begin
            rbuf_d = rbuf_q;
          end
          wd_d       = wd_q + 3'd1;
          wait_cnt_d = 8'd0;
          if ((wd_q + 3'd1) == len_q) begin
            finish_s = 1'b1;
          end else begin
            frame_d = ((len_q - wd_q) == 3'd2);
            ad_d    = wbuf_q[wd_q[1:0] + 2'd1];
          end
        end else if (!dev_seen_now_s) begin
          if (dev_cnt_q == DEV_LAST) begin
            err_abort_d = 1'b1;
            finish_s    = 1'b1;
          end else begin
            dev_cnt_d = dev_cnt_q + 8'd1;
          end
        end else if (!devsel) begin
          if (wait_cnt_q == WAIT_LAST) begin
            err_timeout_d = 1'b1;
            finish_s      = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end else begin
          wait_cnt_d = 8'd0;
        end

        if (finish_s) begin
          state_d = S_TURN;
          frame_d = 1'b1;
          irdy_d  = 1'b1;
          ad_oe_d = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_DATA;
        end
      end

      S_TURN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        frame_d = 1'b1;
        irdy_d  = 1'b1;
        ad_oe_d = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        frame_d = 1'b1;
        irdy_d  = 1'b1;
        ad_oe_d = 1'b0;
      end
    endcase
  end

  // State and output registers; asynchronous reset returns to IDLE and frees the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cmd_write_q   <= 1'b0;
      len_q         <= 3'd0;
      be_q          <= 4'd0;
      wd_q          <= 3'd0;
      dev_cnt_q     <= 8'd0;
      dev_seen_q    <= 1'b0;
      wait_cnt_q    <= 8'd0;
      frame_q       <= 1'b1;
      irdy_q        <= 1'b1;
      cbe_q         <= 4'd0;
      ad_q          <= 32'd0;
      ad_oe_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_abort_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        wbuf_q[i] <= 32'd0;
        rbuf_q[i] <= 32'd0;
      end
    end else begin
      state_q       <= state_d;
      cmd_write_q   <= cmd_write_d;
      len_q         <= len_d;
      be_q          <= be_d;
      wd_q          <= wd_d;
      dev_cnt_q     <= dev_cnt_d;
      dev_seen_q    <= dev_seen_d;
      wait_cnt_q    <= wait_cnt_d;
      frame_q       <= frame_d;
      irdy_q        <= irdy_d;
      cbe_q         <= cbe_d;
      ad_q          <= ad_d;
      ad_oe_q       <= ad_oe_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_abort_q   <= err_abort_d;
      err_timeout_q <= err_timeout_d;
      for (int i = 0; i < 4; i++) begin
        wbuf_q[i] <= wbuf_d[i];
        rbuf_q[i] <= rbuf_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pci_initiator.sv
// Directed bench for pci_initiator with a small behavioural PCI target that
// decodes 0x300-0x302, claims with one wait cycle and can withhold trdy.
module tb_pci_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, cmd_write, wbuf_load;
  logic [31:0] start_addr, wbuf_data;
  logic [2:0]  xfer_len;
  logic [3:0]  byte_en;
  logic [1:0]  wbuf_idx, rbuf_idx;
  logic [31:0] rbuf_data;
  wire  [31:0] ad;
  logic [3:0]  cbe;
  logic        frame, irdy, trdy, devsel;
  logic        busy, done, err_abort, err_timeout;
  logic [2:0]  words_done;

  int n_cmp = 0;
  int n_bad = 0;

  // target model state
  logic [31:0] tb_ad_drv;
  logic        tb_ad_oe;
  logic [31:0] tgt_mem [4];
  logic [31:0] tgt_rd_data [4];
  logic [3:0]  tgt_dev_delay;
  logic [2:0]  tgt_stall_after;
  logic        tgt_active, tgt_is_write;
  logic [1:0]  tgt_base, tgt_idx;
  logic [3:0]  tgt_cnt;
  logic [2:0]  tgt_words;
  logic [31:0] tgt_bmask;

  assign ad        = tb_ad_oe ? tb_ad_drv : {32{1'bz}};
  assign tgt_idx   = tgt_base + tgt_words[1:0];
  assign tgt_bmask = {{8{cbe[3]}}, {8{cbe[2]}}, {8{cbe[1]}}, {8{cbe[0]}}};

  always #5 clk = ~clk;

  pci_initiator dut (
    .clk(clk), .rst(rst), .start(start), .cmd_write(cmd_write),
    .start_addr(start_addr), .xfer_len(xfer_len), .byte_en(byte_en),
    .wbuf_load(wbuf_load), .wbuf_idx(wbuf_idx), .wbuf_data(wbuf_data),
    .rbuf_idx(rbuf_idx), .rbuf_data(rbuf_data), .ad(ad), .cbe(cbe),
    .frame(frame), .irdy(irdy), .trdy(trdy), .devsel(devsel),
    .busy(busy), .done(done), .err_abort(err_abort),
    .err_timeout(err_timeout), .words_done(words_done)
  );

  // Target: decode the address phase and track completed data phases.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      tgt_active <= 1'b0;
      tgt_cnt    <= 4'd0;
      tgt_words  <= 3'd0;
      for (int i = 0; i < 4; i++) tgt_mem[i] <= 32'd0;
    end else if (!tgt_active) begin
      if (frame === 1'b0 && irdy === 1'b1 && ad >= 32'h300 && ad <= 32'h302) begin
        tgt_active   <= 1'b1;
        tgt_is_write <= (cbe == 4'b0011);
        tgt_base     <= ad[1:0];
        tgt_cnt      <= 4'd0;
        tgt_words    <= 3'd0;
      end
    end else begin
      if (tgt_cnt != 4'hF) tgt_cnt <= tgt_cnt + 4'd1;
      if (irdy === 1'b0 && trdy === 1'b0) begin
        if (tgt_is_write) tgt_mem[tgt_idx] <= (tgt_mem[tgt_idx] & ~tgt_bmask) | (ad & tgt_bmask);
        tgt_words <= tgt_words + 3'd1;
        if (frame === 1'b1) tgt_active <= 1'b0;
      end else if (irdy === 1'b1) begin
        tgt_active <= 1'b0;
      end
    end
  end

  // Target: drive devsel/trdy/read data on the falling edge.
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      devsel <= 1'b1; trdy <= 1'b1; tb_ad_oe <= 1'b0;
    end else if (tgt_active && tgt_cnt >= tgt_dev_delay) begin
      devsel    <= 1'b0;
      trdy      <= (tgt_words < tgt_stall_after) ? 1'b0 : 1'b1;
      tb_ad_oe  <= ~tgt_is_write;
      tb_ad_drv <= tgt_rd_data[tgt_idx];
    end else begin
      devsel <= 1'b1; trdy <= 1'b1; tb_ad_oe <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] len, input logic [3:0] be);
    start = 1'b1; cmd_write = wr; start_addr = addr; xfer_len = len; byte_en = be;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (frame !== 1'b1) begin n_bad++; $display("FAIL rst_frame: got %b want 1", frame); end
    n_cmp++; if (irdy !== 1'b1) begin n_bad++; $display("FAIL rst_irdy: got %b want 1", irdy); end
    n_cmp++; if (cbe !== 4'd0) begin n_bad++; $display("FAIL rst_cbe: got %h want 0", cbe); end
    n_cmp++; if (dut.ad_oe_q !== 1'b0) begin n_bad++; $display("FAIL rst_ad_float: got %b want 0", dut.ad_oe_q); end
    n_cmp++; if ({busy, done, err_abort, err_timeout} !== 4'b0000) begin n_bad++; $display("FAIL rst_status: got %b want 0000", {busy, done, err_abort, err_timeout}); end
    n_cmp++; if (words_done !== 3'd0) begin n_bad++; $display("FAIL rst_words: got %0d want 0", words_done); end
    n_cmp++; if (rbuf_data !== 32'd0) begin n_bad++; $display("FAIL rst_rbuf: got %h want 0", rbuf_data); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    int cyc;
    wbuf_load = 1'b1; wbuf_idx = 2'd0; wbuf_data = 32'hDEADBEEF;
    tick();
    wbuf_load = 1'b0;
    issue(1'b1, 32'h300, 3'd1, 4'hF);
    n_cmp++; if ({frame, irdy} !== 2'b01) begin n_bad++; $display("FAIL wr_addr_ctl: got %b want 01", {frame, irdy}); end
    n_cmp++; if (cbe !== 4'b0011) begin n_bad++; $display("FAIL wr_addr_cmd: got %h want 3", cbe); end
    n_cmp++; if (ad !== 32'h300) begin n_bad++; $display("FAIL wr_addr_ad: got %h want 300", ad); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy: got %b want 1", busy); end
    tick();
    n_cmp++; if ({frame, irdy} !== 2'b10) begin n_bad++; $display("FAIL wr_data_ctl: got %b want 10", {frame, irdy}); end
    n_cmp++; if (cbe !== 4'hF) begin n_bad++; $display("FAIL wr_data_be: got %h want f", cbe); end
    n_cmp++; if (ad !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_data_ad: got %h want deadbeef", ad); end
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin tick(); cyc++; end
    n_cmp++; if (cyc != 2) begin n_bad++; $display("FAIL wr_done_latency: got %0d want 2", cyc); end
    n_cmp++; if (words_done !== 3'd1) begin n_bad++; $display("FAIL wr_words: got %0d want 1", words_done); end
    n_cmp++; if ({err_abort, err_timeout} !== 2'b00) begin n_bad++; $display("FAIL wr_errs: got %b want 00", {err_abort, err_timeout}); end
    n_cmp++; if (tgt_mem[0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_target_mem: got %h want deadbeef", tgt_mem[0]); end
    tick();
    n_cmp++; if ({done, busy} !== 2'b00) begin n_bad++; $display("FAIL wr_idle: got %b want 00", {done, busy}); end
  endtask

  task automatic test_burst_read();
    int cyc;
    logic [31:0] exp_rd [3];
    exp_rd[0] = 32'h11; exp_rd[1] = 32'h22; exp_rd[2] = 32'h33;
    issue(1'b0, 32'h300, 3'd3, 4'hF);
    n_cmp++; if (cbe !== 4'b0010) begin n_bad++; $display("FAIL rd_addr_cmd: got %h want 2", cbe); end
    tick();
    n_cmp++; if (dut.ad_oe_q !== 1'b0) begin n_bad++; $display("FAIL rd_ad_float: got %b want 0", dut.ad_oe_q); end
    n_cmp++; if ({frame, irdy} !== 2'b00) begin n_bad++; $display("FAIL rd_data_ctl: got %b want 00", {frame, irdy}); end
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      tick(); cyc++;
      if (done !== 1'b1) begin
        n_cmp++; if (dut.ad_oe_q !== 1'b0) begin n_bad++; $display("FAIL rd_ad_float_mid: got %b want 0", dut.ad_oe_q); end
      end
    end
    n_cmp++; if (cyc != 4) begin n_bad++; $display("FAIL rd_done_latency: got %0d want 4", cyc); end
    n_cmp++; if (words_done !== 3'd3) begin n_bad++; $display("FAIL rd_words: got %0d want 3", words_done); end
    for (int i = 0; i < 3; i++) begin
      rbuf_idx = 2'(i);
      #1;
      n_cmp++; if (rbuf_data !== exp_rd[i]) begin n_bad++; $display("FAIL rd_rbuf%0d: got %h want %h", i, rbuf_data, exp_rd[i]); end
    end
    rbuf_idx = 2'd0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rd_idle: got %b want 0", busy); end
  endtask

  task automatic test_byte_enable();
    int cyc;
    // Load coinciding with start must still land in the buffer.
    wbuf_load = 1'b1; wbuf_idx = 2'd0; wbuf_data = 32'hAABBCCDD;
    issue(1'b1, 32'h302, 3'd1, 4'b0011);
    wbuf_load = 1'b0;
    tick();
    n_cmp++; if (cbe !== 4'b0011) begin n_bad++; $display("FAIL be_cbe: got %b want 0011", cbe); end
    n_cmp++; if (ad !== 32'hAABBCCDD) begin n_bad++; $display("FAIL be_ad: got %h want aabbccdd", ad); end
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin tick(); cyc++; end
    n_cmp++; if (cyc != 2) begin n_bad++; $display("FAIL be_done_latency: got %0d want 2", cyc); end
    n_cmp++; if (tgt_mem[2] !== 32'h0000CCDD) begin n_bad++; $display("FAIL be_target_mem: got %h want 0000ccdd", tgt_mem[2]); end
    tick();
  endtask

  task automatic test_master_abort();
    int cyc;
    issue(1'b0, 32'h400, 3'd2, 4'hF);
    tick();
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin tick(); cyc++; end
    n_cmp++; if (cyc != 4) begin n_bad++; $display("FAIL ma_latency: got %0d want 4", cyc); end
    n_cmp++; if ({frame, irdy} !== 2'b11) begin n_bad++; $display("FAIL ma_bus: got %b want 11", {frame, irdy}); end
    n_cmp++; if ({err_abort, err_timeout} !== 2'b10) begin n_bad++; $display("FAIL ma_errs: got %b want 10", {err_abort, err_timeout}); end
    n_cmp++; if (words_done !== 3'd0) begin n_bad++; $display("FAIL ma_words: got %0d want 0", words_done); end
    tick();
    n_cmp++; if ({done, busy, err_abort} !== 3'b001) begin n_bad++; $display("FAIL ma_hold: got %b want 001", {done, busy, err_abort}); end
  endtask

  task automatic test_stall();
    int cyc;
    for (int i = 0; i < 4; i++) begin
      wbuf_load = 1'b1; wbuf_idx = 2'(i); wbuf_data = 32'h10000001 + 32'(i);
      tick();
    end
    wbuf_load = 1'b0;
    tgt_stall_after = 3'd3;
    issue(1'b1, 32'h300, 3'd4, 4'hF);
    n_cmp++; if (err_abort !== 1'b0) begin n_bad++; $display("FAIL st_abort_cleared: got %b want 0", err_abort); end
    tick();
    cyc = 0;
    while (done !== 1'b1 && cyc < 60) begin tick(); cyc++; end
    n_cmp++; if (cyc != 12) begin n_bad++; $display("FAIL st_latency: got %0d want 12", cyc); end
    n_cmp++; if (words_done !== 3'd3) begin n_bad++; $display("FAIL st_words: got %0d want 3", words_done); end
    n_cmp++; if ({err_abort, err_timeout} !== 2'b01) begin n_bad++; $display("FAIL st_errs: got %b want 01", {err_abort, err_timeout}); end
    n_cmp++; if ({frame, irdy, dut.ad_oe_q} !== 3'b110) begin n_bad++; $display("FAIL st_bus: got %b want 110", {frame, irdy, dut.ad_oe_q}); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (tgt_mem[i] !== 32'h10000001 + 32'(i)) begin n_bad++; $display("FAIL st_mem%0d: got %h want %h", i, tgt_mem[i], 32'h10000001 + 32'(i)); end
    end
    tick();
    n_cmp++; if ({busy, err_timeout} !== 2'b01) begin n_bad++; $display("FAIL st_hold: got %b want 01", {busy, err_timeout}); end
    tgt_stall_after = 3'd7;
  endtask

  task automatic test_bad_len();
    logic [2:0] lens [2];
    lens[0] = 3'd0; lens[1] = 3'd5;
    for (int i = 0; i < 2; i++) begin
      issue(1'b1, 32'h300, lens[i], 4'hF);
      n_cmp++; if ({done, busy, frame} !== 3'b101) begin n_bad++; $display("FAIL badlen%0d: got %b want 101", lens[i], {done, busy, frame}); end
      tick();
      n_cmp++; if ({done, busy, frame} !== 3'b001) begin n_bad++; $display("FAIL badlen%0d_after: got %b want 001", lens[i], {done, busy, frame}); end
    end
  endtask

  task automatic test_reset_mid_burst();
    issue(1'b0, 32'h300, 3'd3, 4'hF);
    tick(); tick(); tick();
    n_cmp++; if (words_done !== 3'd1) begin n_bad++; $display("FAIL rm_words_before: got %0d want 1", words_done); end
    rst = 1'b0;
    #1;
    n_cmp++; if ({frame, irdy, dut.ad_oe_q, busy} !== 4'b1100) begin n_bad++; $display("FAIL rm_release: got %b want 1100", {frame, irdy, dut.ad_oe_q, busy}); end
    n_cmp++; if (rbuf_data !== 32'd0) begin n_bad++; $display("FAIL rm_rbuf_cleared: got %h want 0", rbuf_data); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rm_no_done: got %b want 0", done); end
    end
    rst = 1'b1;
    tick();
    n_cmp++; if ({busy, done, frame} !== 3'b001) begin n_bad++; $display("FAIL rm_idle: got %b want 001", {busy, done, frame}); end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; cmd_write = 1'b0; wbuf_load = 1'b0;
    start_addr = 32'd0; wbuf_data = 32'd0; xfer_len = 3'd0; byte_en = 4'd0;
    wbuf_idx = 2'd0; rbuf_idx = 2'd0; tb_ad_drv = 32'd0; tgt_is_write = 1'b0; tgt_base = 2'd0;
    tgt_dev_delay = 4'd1; tgt_stall_after = 3'd7;
    tgt_rd_data[0] = 32'h11; tgt_rd_data[1] = 32'h22;
    tgt_rd_data[2] = 32'h33; tgt_rd_data[3] = 32'h44;
    test_reset();
    test_single_write();
    test_burst_read();
    test_byte_enable();
    test_master_abort();
    test_stall();
    test_bad_len();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pci_initiator.md
Name: pci_initiator

Overview:
- Bus-master stage that sits directly upstream of the PCI target on the shared frame/irdy/trdy/devsel/ad/cbe bus.
- Accepts a host command: read or write, start address, and 1-4 data words.
- Runs the PCI address phase and the data phases, handling target wait states, master abort and target stall.
- Read data lands in a 4-entry read buffer. Write data comes from a 4-entry write buffer the host preloads.

Parameters:
- DEVSEL_TIMEOUT, 4, cycles in DATA without devsel low before a master abort.
- WAIT_LIMIT, 8, consecutive cycles with devsel low and trdy high before a stall termination.

Ports:
- clk  input  1  bus clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle command strobe, sampled only in IDLE
- cmd_write  input  1  1 = write (cbe 4'b0011), 0 = read (cbe 4'b0010)
- start_addr  input  32  address driven in the address phase (target decodes 0x300-0x302)
- xfer_len  input  3  number of data phases, legal 1-4
- byte_en  input  4  driven on cbe in every data phase; 1 = lane enabled (matches the target's mask convention)
- wbuf_load  input  1  write-buffer load strobe, ignored while busy
- wbuf_idx  input  2  write-buffer entry to load
- wbuf_data  input  32  write-buffer data
- rbuf_idx  input  2  read-buffer select
- rbuf_data  output  32  read-buffer entry selected by rbuf_idx (combinational)
- ad  inout  32  multiplexed address/data
- cbe  output  4  command, then byte enables
- frame  output  1  active-low
- irdy  output  1  active-low
- trdy  input  1  active-low, from the target
- devsel  input  1  active-low, from the target
- busy  output  1  high from IDLE exit until return to IDLE
- done  output  1  one-cycle pulse when a transaction ends (normal or error)
- err_abort  output  1  master abort; held until the next start
- err_timeout  output  1  stall termination; held until the next start
- words_done  output  3  number of completed data phases in the last or current transaction

Behaviour:
- All state and outputs are registered on posedge clk. trdy and devsel are sampled at posedge. The target drives them on negedge, so they are stable by then.
- Reset (rst low, asynchronous):
  - frame=1, irdy=1, cbe=0, ad=Z.
  - busy=0, done=0, err_abort=0, err_timeout=0, words_done=0.
  - Both buffers cleared; FSM goes to IDLE.
  - Reset mid-transaction releases the bus immediately.
- IDLE:
  - start=1 with xfer_len in 1..4 latches cmd_write, start_addr, xfer_len and byte_en.
  - It clears the error flags and words_done and sets busy; next state ADDR.
  - xfer_len of 0 or greater than 4: start is ignored and done pulses with no bus activity.
- ADDR (1 cycle): frame=0, irdy=1, ad=start_addr, cbe=command; next state DATA.
- DATA:
  - irdy=0, cbe=byte_en.
  - ad = wbuf[words_done] for writes; ad = Z for reads (no separate turnaround cycle).
  - frame=1 once the current phase is the final one (remaining==1); otherwise frame=0.
  - A phase completes at a posedge with irdy=0 and trdy=0. On completion, a read captures ad into rbuf[words_done], then words_done increments.
  - After the final completion, next state TURN.
- Master abort:
  - Triggered when devsel stays high for DEVSEL_TIMEOUT cycles after entering DATA.
  - Response: frame=1, irdy=1, err_abort=1, next state TURN.
- Stall:
  - Triggered when devsel=0 and trdy=1 for WAIT_LIMIT consecutive cycles (the target withholds trdy when its memory is full).
  - Response: err_timeout=1, frame=1, irdy=1, next state TURN.
  - The stall counter resets on every completed phase.
- TURN (1 cycle): frame=1, irdy=1, ad=Z, done=1; next state IDLE, busy=0.
- Simultaneous events:
  - Completion and stall-limit in the same cycle: completion wins.
  - start while busy: ignored.
  - wbuf_load in the same cycle as start: the load is applied.
- ad is never driven outside ADDR, and outside DATA during writes.

Test Plan:
- Single write: load wbuf0=0xDEADBEEF, start write at 0x300, len 1, byte_en 4'hF, target responds with medium devsel → one data phase with ad=0xDEADBEEF, frame high in the data phase, done pulse, words_done=1, no errors.
- Burst read: start read at 0x300, len 3, target holds 0x11, 0x22, 0x33 → rbuf0..2=0x11, 0x22, 0x33, words_done=3, ad undriven by the initiator during DATA.
- Master abort: start at 0x400 (unclaimed), len 2 → after 4 DATA cycles frame=1, irdy=1, err_abort=1, done pulse, words_done=0.
- Stall: write len 4 to a target that drops trdy after 3 words → words_done=3, err_timeout=1 after 8 stalled cycles, bus released.
- Byte enables: write 0xAABBCCDD with byte_en 4'b0011 → cbe=4'b0011 in the data phase; target stores 0x0000CCDD.
- Reset mid-burst: assert rst during the 2nd read phase → frame=1, irdy=1, ad=Z and busy=0 immediately; no done pulse.
